// File: rtl/aim_scan_if.sv
// aim_scan_if: start/config/query inputs and result outputs of the aim_scan matcher.
//   master: drives i_start, i_mode, i_ite, i_word, i_IA; observes o_busy, o_finish, o_err, o_valid, o_pos
//   slave : the matcher side of the same signals
interface aim_scan_if #(
  parameter int N_WORDS = 32,
  parameter int WORD_W  = 16,
  parameter int IA_W    = 6,
  parameter int DEPTH   = 256,
  parameter int ITE_W   = 3,
  parameter int POS_W   = 9
);
  logic                       i_start;
  logic                       i_mode;
  logic [ITE_W-1:0]           i_ite;
  logic [N_WORDS*WORD_W-1:0]  i_word;
  logic [DEPTH*IA_W-1:0]      i_IA;
  logic                       o_busy;
  logic                       o_finish;
  logic                       o_err;
  logic [N_WORDS-1:0]         o_valid;
  logic [N_WORDS*POS_W-1:0]   o_pos;
  modport master (
    output i_start, i_mode, i_ite, i_word, i_IA,
    input  o_busy, o_finish, o_err, o_valid, o_pos
  );
  modport slave (
    input  i_start, i_mode, i_ite, i_word, i_IA,
    output o_busy, o_finish, o_err, o_valid, o_pos
  );
endinterface

// File: rtl/aim_scan.sv
// aim_scan: multi-beat key search of N_WORDS query keys over a DEPTH-entry index array, LANES entries per beat.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : aim_scan_if slave (start/mode/ite/word/IA in; busy/finish/err/valid/pos out)
module aim_scan #(
  parameter int N_WORDS  = 32,
  parameter int WORD_W   = 16,
  parameter int IA_W     = 6,
  parameter int DEPTH    = 256,
  parameter int LANES    = 16,
  parameter int KEY_STEP = 2,
  parameter int ITE_W    = 3,
  parameter int POS_W    = 9
) (
  input logic         i_clk,
  input logic         i_rst_n,
  aim_scan_if.slave   bus
);
  localparam int B   = DEPTH / LANES;
  localparam int B_W = (B > 1) ? $clog2(B) : 1;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t                    state_q, state_d;
  logic [B_W-1:0]            b_q, b_d;
  logic                      mode_q, mode_d;
  logic [N_WORDS*IA_W-1:0]   key_q, key_d, key_new;
  logic [DEPTH*IA_W-1:0]     ia_q, ia_d;
  logic [N_WORDS-1:0]        valid_q, valid_d;
  logic [N_WORDS*POS_W-1:0]  pos_q, pos_d;
  logic                      err_q, err_d;
  logic                      finish_q, finish_d;
  logic [N_WORDS-1:0]        hit;
  logic [N_WORDS*POS_W-1:0]  hpos;
  logic                      legal;
  int                        off, offc, j;
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    mode_d   = mode_q;
    key_d    = key_q;
    ia_d     = ia_q;
    valid_d  = valid_q;
    pos_d    = pos_q;
    err_d    = err_q;
    finish_d = 1'b0;
    hit      = '0;
    hpos     = '0;
    key_new  = '0;
    j        = 0;
    off      = int'(bus.i_ite) * KEY_STEP;
    legal    = (off + IA_W) <= WORD_W;
    // clamp keeps the part-select in range when the index is rejected anyway
    offc     = legal ? off : 0;
    for (int k = 0; k < N_WORDS; k++)
      key_new[k*IA_W +: IA_W] = bus.i_word[k*WORD_W + offc +: IA_W];
    // walk lanes so the preferred match (lowest in mode 0, highest in mode 1) is written last
    for (int k = 0; k < N_WORDS; k++)
      for (int l = 0; l < LANES; l++) begin
        j = int'(b_q) * LANES + (mode_q ? l : LANES - 1 - l);
        if (ia_q[j*IA_W +: IA_W] == key_q[k*IA_W +: IA_W]) begin
          hit[k] = 1'b1;
          hpos[k*POS_W +: POS_W] = POS_W'(j);
        end
      end
    if (state_q == IDLE) begin
      if (bus.i_start) begin
        valid_d = '0;
        pos_d   = '0;
        b_d     = '0;
        if (legal) begin
          state_d = SCAN;
          mode_d  = bus.i_mode;
          key_d   = key_new;
          ia_d    = bus.i_IA;
          err_d   = 1'b0;
        end else begin
          err_d    = 1'b1;
          finish_d = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N_WORDS; k++)
        if (hit[k] && (mode_q || !valid_q[k])) begin
          valid_d[k] = 1'b1;
          pos_d[k*POS_W +: POS_W] = hpos[k*POS_W +: POS_W];
        end
      b_d = b_q + 1'b1;
      if (b_q == B_W'(B - 1) || (!mode_q && (&valid_d))) begin
        state_d  = IDLE;
        finish_d = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      b_q      <= '0;
      mode_q   <= 1'b0;
      key_q    <= '0;
      ia_q     <= '0;
      valid_q  <= '0;
      pos_q    <= '0;
      err_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      key_q    <= key_d;
      ia_q     <= ia_d;
      valid_q  <= valid_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      finish_q <= finish_d;
    end
  end
  assign bus.o_busy   = (state_q == SCAN);
  assign bus.o_finish = finish_q;
  assign bus.o_err    = err_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_pos    = pos_q;
endmodule
